// File: rtl/opsum_pkg.sv
// Shared types and elaboration helpers for the operand-sum pipeline.
// Holds clog2, the tree-depth derivation and the per-level width rule.
package opsum_pkg;

    // Sideband that travels with each beat through the tree.
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } beat_tag_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < n) r++;
        end
        return r;
    endfunction

    function automatic int tree_st(input int num_ops);
        return clog2(num_ops);
    endfunction

    // Output width of reduction level j.
    function automatic int lvl_w(input int op_w, input int j);
        return op_w + j + 1;
    endfunction

endpackage

// File: rtl/opsum_if.sv
// Beat-in / result-out bundle of opsum_pipe.
// master: producer + consumer side; slave: the pipeline.
// OPSUM_THRESHOLD_EN adds thresh (in) and out_fire (out).
interface opsum_if #(
    parameter int NUM_OPS = 12,
    parameter int OP_W    = 4,
    parameter int ACC_W   = 16
);
    logic [NUM_OPS*OP_W-1:0] op;
    logic                    in_valid;
    logic                    in_first;
    logic                    in_last;
    logic                    in_ready;
    logic [ACC_W-1:0]        out_sum;
    logic                    out_ovf;
    logic                    out_valid;
    logic                    out_ready;
`ifdef OPSUM_THRESHOLD_EN
    logic [ACC_W-1:0]        thresh;
    logic                    out_fire;
`endif

    modport master (
        output op, in_valid, in_first, in_last, out_ready,
`ifdef OPSUM_THRESHOLD_EN
        output thresh,
        input  out_fire,
`endif
        input  in_ready, out_sum, out_ovf, out_valid
    );

    modport slave (
        input  op, in_valid, in_first, in_last, out_ready,
`ifdef OPSUM_THRESHOLD_EN
        input  thresh,
        output out_fire,
`endif
        output in_ready, out_sum, out_ovf, out_valid
    );

endinterface

// File: rtl/opsum_add_stage.sv
// One registered pairwise-add level of the reduction tree.
// Ports: clk, reset, en (advance), in_sum/in_tag -> out_sum/out_tag.
module opsum_add_stage
    import opsum_pkg::*;
#(
    parameter int N_IN = 2,
    parameter int IN_W = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [N_IN*IN_W-1:0]          in_sum,
    input  beat_tag_t                     in_tag,
    output logic [N_IN/2*(IN_W+1)-1:0]    out_sum,
    output beat_tag_t                     out_tag
);

    logic [N_IN/2*(IN_W+1)-1:0] sum_nxt;

    always_comb begin
        sum_nxt = '0;
        for (int k = 0; k < N_IN / 2; k++) begin
            sum_nxt[k*(IN_W+1) +: IN_W+1] =
                {1'b0, in_sum[2*k*IN_W +: IN_W]} +
                {1'b0, in_sum[(2*k+1)*IN_W +: IN_W]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_sum <= '0;
            out_tag <= '0;
        end else if (en) begin
            out_sum <= sum_nxt;
            out_tag <= in_tag;
        end
    end

endmodule

// File: rtl/opsum_pipe.sv
// Pipelined operand summer: adder tree + saturating frame accumulator.
// Ports: clk, reset (sync, active-high), bus (opsum_if.slave).
// Macro OPSUM_THRESHOLD_EN: registers out_fire = out_sum >= thresh.
module opsum_pipe
    import opsum_pkg::*;
#(
    parameter int NUM_OPS = 12,
    parameter int OP_W    = 4,
    parameter int ACC_W   = 16
) (
    input  logic    clk,
    input  logic    reset,
    opsum_if.slave  bus
);

    localparam int TREE_ST = tree_st(NUM_OPS);
    localparam int TW      = OP_W + TREE_ST;

    logic             adv;
    beat_tag_t        in_tag;
    logic [TW-1:0]    tree_sum;
    beat_tag_t        tree_tag;

    logic [ACC_W-1:0] acc;
    logic             ovf;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W:0]   tree_ext;
    logic [ACC_W-1:0] acc_nxt;
    logic             ovf_nxt;

    // Whole pipeline moves in lockstep; a held result freezes it.
    assign adv          = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = adv;

    assign in_tag.valid = bus.in_valid;
    assign in_tag.first = bus.in_first;
    assign in_tag.last  = bus.in_last;

    if (TREE_ST == 0) begin : g_direct
        assign tree_sum = bus.op;
        assign tree_tag = in_tag;
    end else begin : g_tree
        localparam int NLEAF = 1 << TREE_ST;

        logic [NLEAF*OP_W-1:0] leaves;

        if (NLEAF > NUM_OPS) begin : g_pad
            assign leaves = {{((NLEAF-NUM_OPS)*OP_W){1'b0}}, bus.op};
        end else begin : g_nopad
            assign leaves = bus.op;
        end

        for (genvar j = 0; j < TREE_ST; j++) begin : g_lvl
            localparam int IW = OP_W + j;
            localparam int NI = 1 << (TREE_ST - j);

            logic [NI*IW-1:0]                src;
            beat_tag_t                       src_tag;
            logic [NI/2*lvl_w(OP_W, j)-1:0]  sum;
            beat_tag_t                       tag;

            if (j == 0) begin : g_src
                assign src     = leaves;
                assign src_tag = in_tag;
            end else begin : g_src
                assign src     = g_lvl[j-1].sum;
                assign src_tag = g_lvl[j-1].tag;
            end

            opsum_add_stage #(
                .N_IN (NI),
                .IN_W (IW)
            ) u_stage (
                .clk     (clk),
                .reset   (reset),
                .en      (adv),
                .in_sum  (src),
                .in_tag  (src_tag),
                .out_sum (sum),
                .out_tag (tag)
            );
        end

        assign tree_sum = g_lvl[TREE_ST-1].sum;
        assign tree_tag = g_lvl[TREE_ST-1].tag;
    end

    // A first beat restarts the frame, discarding partial sum and ovf.
    always_comb begin
        acc_base = tree_tag.first ? '0 : acc;
        tree_ext = {{(ACC_W+1-TW){1'b0}}, tree_sum};
        acc_sum  = {1'b0, acc_base} + tree_ext;
        acc_nxt  = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
        ovf_nxt  = (tree_tag.first ? 1'b0 : ovf) | acc_sum[ACC_W];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc           <= '0;
            ovf           <= 1'b0;
            bus.out_sum   <= '0;
            bus.out_ovf   <= 1'b0;
            bus.out_valid <= 1'b0;
`ifdef OPSUM_THRESHOLD_EN
            bus.out_fire  <= 1'b0;
`endif
        end else if (adv) begin
            bus.out_valid <= tree_tag.valid && tree_tag.last;
            if (tree_tag.valid) begin
                if (tree_tag.last) begin
                    // Frame done: publish and zero for the next one.
                    acc          <= '0;
                    ovf          <= 1'b0;
                    bus.out_sum  <= acc_nxt;
                    bus.out_ovf  <= ovf_nxt;
`ifdef OPSUM_THRESHOLD_EN
                    bus.out_fire <= (acc_nxt >= bus.thresh);
`endif
                end else begin
                    acc <= acc_nxt;
                    ovf <= ovf_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_opsum_pipe.sv
// Self-checking bench for opsum_pipe: default instance plus an
// ACC_W=8 instance fed the same stream to exercise saturation.
module tb_opsum_pipe;

    localparam int     NOPS = 12;
    localparam int     OPW  = 4;
    localparam int     OPB  = NOPS * OPW;
    localparam longint THR  = 100;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    opsum_if #(.NUM_OPS(NOPS), .OP_W(OPW), .ACC_W(16)) bus ();
    opsum_if #(.NUM_OPS(NOPS), .OP_W(OPW), .ACC_W(8))  bus2 ();

    opsum_pipe #(.NUM_OPS(NOPS), .OP_W(OPW), .ACC_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    opsum_pipe #(.NUM_OPS(NOPS), .OP_W(OPW), .ACC_W(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    assign bus2.op        = bus.op;
    assign bus2.in_valid  = bus.in_valid;
    assign bus2.in_first  = bus.in_first;
    assign bus2.in_last   = bus.in_last;
    assign bus2.out_ready = bus.out_ready;
`ifdef OPSUM_THRESHOLD_EN
    assign bus2.thresh    = bus.thresh[7:0];
`endif

    typedef struct {
        longint sum;
        bit     ovf;
        bit     fire;
    } exp_t;

    typedef struct {
        logic [OPB-1:0] op;
        longint         sum;
    } vec_t;

    exp_t   q1[$];
    exp_t   q2[$];
    longint macc[2];
    bit     movf[2];
    int     n_checks = 0;
    int     n_pass   = 0;

    task automatic check(input string nm, input longint act,
                         input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", nm, act, exp);
    endtask

    function automatic longint opsum(input logic [OPB-1:0] o);
        longint s = 0;
        for (int k = 0; k < NOPS; k++) s += longint'(o[k*OPW +: OPW]);
        return s;
    endfunction

    // Frame-level reference: sum every accepted beat, saturate, emit on last.
    function automatic void model(input int d, input logic [OPB-1:0] o,
                                  input logic f, input logic l);
        longint mx = (d == 0) ? 65535 : 255;
        exp_t   e;
        if (f) begin
            macc[d] = 0;
            movf[d] = 0;
        end
        macc[d] += opsum(o);
        if (macc[d] > mx) begin
            macc[d] = mx;
            movf[d] = 1;
        end
        if (l) begin
            e.sum  = macc[d];
            e.ovf  = movf[d];
            e.fire = (macc[d] >= THR);
            if (d == 0) q1.push_back(e);
            else q2.push_back(e);
            macc[d] = 0;
            movf[d] = 0;
        end
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        if (reset) begin
            q1.delete();
            q2.delete();
            macc[0] = 0; macc[1] = 0;
            movf[0] = 0; movf[1] = 0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                check("sb1_avail", longint'(q1.size() > 0), 1);
                if (q1.size() > 0) begin
                    e = q1.pop_front();
                    check("sb1_sum", longint'(bus.out_sum), e.sum);
                    check("sb1_ovf", longint'(bus.out_ovf), longint'(e.ovf));
`ifdef OPSUM_THRESHOLD_EN
                    check("sb1_fire", longint'(bus.out_fire),
                          longint'(e.fire));
`endif
                end
            end
            if (bus2.out_valid && bus2.out_ready) begin
                check("sb2_avail", longint'(q2.size() > 0), 1);
                if (q2.size() > 0) begin
                    e = q2.pop_front();
                    check("sb2_sum", longint'(bus2.out_sum), e.sum);
                    check("sb2_ovf", longint'(bus2.out_ovf), longint'(e.ovf));
`ifdef OPSUM_THRESHOLD_EN
                    check("sb2_fire", longint'(bus2.out_fire),
                          longint'(e.fire));
`endif
                end
            end
            if (bus.in_valid && bus.in_ready)
                model(0, bus.op, bus.in_first, bus.in_last);
            if (bus2.in_valid && bus2.in_ready)
                model(1, bus2.op, bus2.in_first, bus2.in_last);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [OPB-1:0] o, input logic f,
                        input logic l);
        int n = 0;
        bus.op       = o;
        bus.in_first = f;
        bus.in_last  = l;
        bus.in_valid = 1'b1;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", longint'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // lat counts edges from the accepting edge to out_valid.
    task automatic wait_valid(output int lat);
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            @(negedge clk);
        end
        check("wait_valid", longint'(bus.out_valid), 1);
    endtask

    task automatic get_res(output int lat, output longint s1,
                           output longint o1, output longint s2,
                           output longint o2, output longint fr);
        wait_valid(lat);
        s1 = longint'(bus.out_sum);
        o1 = longint'(bus.out_ovf);
        s2 = longint'(bus2.out_sum);
        o2 = longint'(bus2.out_ovf);
`ifdef OPSUM_THRESHOLD_EN
        fr = longint'(bus.out_fire);
`else
        fr = 0;
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        vec_t           tbl[8];
        int             lat;
        int             bad;
        longint         s1, o1, s2, o2, fr;
        longint         got[$];
        logic [OPB-1:0] all1, all2, all15;

        all1  = 48'h1111_1111_1111;
        all2  = 48'h2222_2222_2222;
        all15 = 48'hFFFF_FFFF_FFFF;

        tbl[0] = '{48'hFFFF_FFFF_FFFF, 180};
        tbl[1] = '{48'h0000_0000_0000, 0};
        tbl[2] = '{48'h0000_0000_0001, 1};
        tbl[3] = '{48'hF000_0000_0000, 15};
        tbl[4] = '{48'hBA98_7654_3210, 66};
        tbl[5] = '{48'h0F0F_0F0F_0F0F, 90};
        tbl[6] = '{48'h1111_1111_1111, 12};
        tbl[7] = '{48'h8000_0000_0008, 16};

        bus.op        = '0;
        bus.in_valid  = 1'b0;
        bus.in_first  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
`ifdef OPSUM_THRESHOLD_EN
        bus.thresh    = 16'(THR);
`endif

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_out_sum", longint'(bus.out_sum), 0);
        check("rst_out_ovf", longint'(bus.out_ovf), 0);
        check("rst_in_ready", longint'(bus.in_ready), 1);
        @(posedge clk);
        #1;

        // Single-beat frames: value and 5-cycle latency.
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].op, 1'b1, 1'b1);
            get_res(lat, s1, o1, s2, o2, fr);
            check($sformatf("tbl%0d_sum", i), s1, tbl[i].sum);
            check($sformatf("tbl%0d_ovf", i), o1, 0);
            check($sformatf("tbl%0d_lat", i), longint'(lat), 5);
        end

        // Three-beat frame.
        send(all1, 1'b1, 1'b0);
        send(all1, 1'b0, 1'b0);
        send(all1, 1'b0, 1'b1);
        get_res(lat, s1, o1, s2, o2, fr);
        check("frame3_sum", s1, 36);

        // Mid-frame first discards partial sum and sticky ovf.
        send(all15, 1'b1, 1'b0);
        send(all15, 1'b0, 1'b0);
        send(all1, 1'b1, 1'b1);
        get_res(lat, s1, o1, s2, o2, fr);
        check("restart_sum", s1, 12);
        check("restart_sum8", s2, 12);
        check("restart_ovf8", o2, 0);

        // Non-first beat after a completed frame starts from zero.
        send(all1, 1'b1, 1'b1);
        get_res(lat, s1, o1, s2, o2, fr);
        send(all2, 1'b0, 1'b1);
        get_res(lat, s1, o1, s2, o2, fr);
        check("nofirst_sum", s1, 24);

        // Saturation on the 8-bit instance, then recovery.
        send(all15, 1'b1, 1'b0);
        send(all15, 1'b0, 1'b1);
        get_res(lat, s1, o1, s2, o2, fr);
        check("sat_sum16", s1, 360);
        check("sat_ovf16", o1, 0);
        check("sat_sum8", s2, 255);
        check("sat_ovf8", o2, 1);
        send(all1, 1'b1, 1'b1);
        get_res(lat, s1, o1, s2, o2, fr);
        check("after_sat_sum8", s2, 12);
        check("after_sat_ovf8", o2, 0);

        // Backpressure with two frames in flight.
        bus.out_ready = 1'b0;
        send(all1, 1'b1, 1'b1);
        send(all2, 1'b1, 1'b1);
        wait_valid(lat);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!(bus.out_valid && !bus.in_ready && bus.out_sum == 16'd12))
                bad++;
            @(posedge clk);
            #1;
            @(negedge clk);
        end
        check("stall_hold", longint'(bad), 0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready)
                got.push_back(longint'(bus.out_sum));
            @(posedge clk);
            #1;
        end
        check("stall_count", longint'(got.size()), 2);
        check("stall_first", (got.size() > 0) ? got[0] : -1, 12);
        check("stall_second", (got.size() > 1) ? got[1] : -1, 24);

        // Reset mid-frame drops in-flight beats.
        send(all1, 1'b1, 1'b0);
        send(all1, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", longint'(bus.out_valid), 0);
        @(posedge clk);
        #1;
        send(all1, 1'b1, 1'b1);
        get_res(lat, s1, o1, s2, o2, fr);
        check("rst_mid_sum", s1, 12);

        send(all2, 1'b1, 1'b0);
        send(all2, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        send(all1, 1'b0, 1'b1);
        get_res(lat, s1, o1, s2, o2, fr);
        check("rst_acc_sum", s1, 12);

`ifdef OPSUM_THRESHOLD_EN
        send(48'h0999_9999_9999, 1'b1, 1'b1);
        get_res(lat, s1, o1, s2, o2, fr);
        check("thr99_sum", s1, 99);
        check("thr99_fire", fr, 0);
        send(48'h0000_0AFF_FFFF, 1'b1, 1'b1);
        get_res(lat, s1, o1, s2, o2, fr);
        check("thr100_sum", s1, 100);
        check("thr100_fire", fr, 1);
`endif

        // Random traffic against the frame model.
        for (int c = 0; c < 600; c++) begin
            reset         = ($urandom_range(0, 149) == 0);
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_first  = ($urandom_range(0, 3) == 0);
            bus.in_last   = ($urandom_range(0, 2) == 0);
            bus.op        = {$urandom(), $urandom()};
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("drain_q1", longint'(q1.size()), 0);
        check("drain_q2", longint'(q2.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/opsum_pipe.md
OPSUM_PIPE -- requirements
Module: opsum_pipe

Interface
REQ-001 The block SHALL have parameter NUM_OPS, default 12, giving the number of operands summed per beat (legal range 1..64).
REQ-002 The block SHALL have parameter OP_W, default 4, giving the unsigned operand width in bits (legal range 1..16).
REQ-003 The block SHALL have parameter ACC_W, default 16, giving the accumulator and result width; ACC_W SHALL be at least OP_W+clog2(NUM_OPS).
REQ-004 The block SHALL run on one clock; reset is synchronous and active-high.
REQ-005 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1 bit: synchronous active-high reset.
REQ-007 Port op, input, NUM_OPS*OP_W bits: packed operands; operand k occupies bits [k*OP_W +: OP_W].
REQ-008 Port in_valid, input, 1 bit: a beat is offered on op.
REQ-009 Port in_first, input, 1 bit: the beat starts a frame.
REQ-010 Port in_last, input, 1 bit: the beat ends a frame.
REQ-011 Port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-012 Port out_sum, output, ACC_W bits: the frame total.
REQ-013 Port out_ovf, output, 1 bit: the frame total saturated.
REQ-014 Port out_valid, output, 1 bit: out_sum and out_ovf are valid.
REQ-015 Port out_ready, input, 1 bit: the consumer accepts the result.

Function
REQ-016 A beat SHALL be accepted when in_valid and in_ready are both high in the same cycle.
REQ-017 The tree SHALL reduce the operands pairwise over TREE_ST=clog2(NUM_OPS) registered levels; odd or missing leaves are zero-padded.
REQ-018 Level j SHALL carry OP_W+j+1 bits, so no carry is ever lost inside the tree.
REQ-019 The pipeline SHALL advance only when adv = !out_valid || out_ready; in_ready SHALL equal adv.
REQ-020 When adv is low, every stage, valid bit and flag SHALL hold its value, so no beat is lost or duplicated.
REQ-021 The accumulator stage SHALL load the tree sum on a first beat and add it to the accumulator otherwise.
REQ-022 If the add would exceed 2^ACC_W-1, the accumulator SHALL be set to all ones and a sticky ovf SHALL be set for the rest of that frame.
REQ-023 When a last beat passes the accumulator stage, the block SHALL register out_sum, out_ovf and out_valid=1.
REQ-024 out_valid SHALL drop after the out_ready handshake unless another last beat completes in the same cycle.
REQ-025 Latency SHALL be TREE_ST+1 cycles from acceptance of a first&last beat to out_valid, with no stalls (5 cycles at the defaults).
REQ-026 A beat with in_first=1 received mid-frame SHALL silently discard the partial sum and clear ovf.
REQ-027 A beat with in_first=0 arriving after a completed frame SHALL accumulate onto the zeroed accumulator.
REQ-028 With NUM_OPS=1, TREE_ST SHALL be 0 and the operand SHALL feed the accumulator directly.
REQ-029 Throughput SHALL be one beat per cycle while out_ready is high.

Reset
REQ-030 Reset SHALL clear all stage valid bits, the accumulator, ovf, out_sum, out_ovf and out_valid to 0, and SHALL take priority over all other events.
REQ-031 A reset asserted mid-frame or mid-stall SHALL drop all in-flight beats; the first result after reset SHALL come from beats accepted after reset.

Configuration
REQ-032 With macro OPSUM_THRESHOLD_EN defined, the block SHALL add input thresh (ACC_W bits) and output out_fire, registered with out_sum, where out_fire = (out_sum >= thresh) evaluated on the final, post-saturation sum.
REQ-033 Without OPSUM_THRESHOLD_EN, thresh and out_fire SHALL be absent and the logic SHALL be unchanged otherwise.

Structure
REQ-034 Package opsum_pkg SHALL hold the clog2 function, the TREE_ST derivation and the per-level width function.
REQ-035 Sub-module opsum_add_stage SHALL implement one registered pairwise reduction level with an enable, instantiated once per tree level by generate.

Verification
REQ-036 Defaults, all operands 15, single first&last beat -> out_sum=180, out_ovf=0, out_valid exactly 5 cycles after acceptance.
REQ-037 Three-beat frame with all operands 1, first on beat 0 and last on beat 2 -> one result, out_sum=36.
REQ-038 out_ready held low for 10 cycles with 2 frames in flight (values 12 and 24) -> out_valid stable, in_ready low; on release, results arrive 12 then 24 with no loss.
REQ-039 ACC_W=8, two-beat frame of 180+180 -> out_sum=255, out_ovf=1; the next frame (one beat, 12) -> out_sum=12, out_ovf=0.
REQ-040 Reset pulsed after beat 1 of a 3-beat frame, then a fresh first&last beat of value 12 -> the only result is 12.
REQ-041 OPSUM_THRESHOLD_EN defined, thresh=100: sums 99 and 100 -> out_fire=0 for 99, then 1 for 100.
